// File: rtl/spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_top engine among N_REQ requesters.
// Optional watchdog on the BUSY wait is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 32,
    parameter int CTRL_W         = 7,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ*CTRL_W-1:0] req_ctrl,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    spi_start,
    output logic [DATA_W-1:0]       spi_input_data,
    output logic [CTRL_W-1:0]       spi_control,
    input  logic [DATA_W-1:0]       spi_output_data,
    input  logic [3:0]              spi_done
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_found;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = last_grant;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = (int'(last_grant) + off) % N_REQ;
            if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] timeout_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            last_grant     <= IDX_W'(N_REQ - 1);
            req_ready      <= '0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
            busy           <= 1'b0;
            spi_start      <= 1'b0;
            spi_input_data <= '0;
            spi_control    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            rsp_err        <= 1'b0;
            timeout_cnt    <= '0;
`endif
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        spi_input_data       <= req_data[grant_idx*DATA_W +: DATA_W];
                        spi_control          <= req_ctrl[grant_idx*CTRL_W +: CTRL_W];
                        spi_start            <= 1'b1;
                        req_ready[grant_idx] <= 1'b1;
                        last_grant           <= grant_idx;
                        busy                 <= 1'b1;
                        state                <= BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
                        timeout_cnt          <= '0;
`endif
                    end
                end
                BUSY: begin
                    // Done takes precedence over a timeout landing in the same cycle.
                    if (|spi_done) begin
                        spi_start             <= 1'b0;
                        rsp_data              <= spi_output_data;
                        rsp_valid[last_grant] <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                        rsp_err               <= 1'b0;
`endif
                        state                 <= DRAIN;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        spi_start             <= 1'b0;
                        rsp_data              <= '0;
                        rsp_valid[last_grant] <= 1'b1;
                        rsp_err               <= 1'b1;
                        state                 <= DRAIN;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (spi_done == 4'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    spi_start <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter: grant order, handshake timing and reset behaviour.
module tb_spi_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_data = '0;
    logic [27:0]  req_ctrl = '0;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic         rsp_err;
    logic         busy;
    logic         spi_start;
    logic [31:0]  spi_input_data;
    logic [6:0]   spi_control;
    logic [31:0]  spi_output_data = '0;
    logic [3:0]   spi_done = '0;

    int n_compared = 0;
    int n_mismatched = 0;

    spi_arbiter #(
        .N_REQ(4), .DATA_W(32), .CTRL_W(7), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ctrl(req_ctrl),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .spi_start(spi_start),
        .spi_input_data(spi_input_data), .spi_control(spi_control),
        .spi_output_data(spi_output_data), .spi_done(spi_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input logic [6:0] c);
        req_data[i*32 +: 32] = d;
        req_ctrl[i*7 +: 7]   = c;
    endtask

    // One-cycle done pulse followed by the DRAIN exit back to IDLE.
    task automatic complete_txn(input logic [31:0] out_val);
        spi_done = 4'b0001;
        spi_output_data = out_val;
        tick();
        spi_done = 4'b0000;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_compared++;
        if ({req_ready, rsp_valid, busy, spi_start, rsp_err} !== 11'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_ctl: got %b expected 0", {req_ready, rsp_valid, busy, spi_start, rsp_err});
        end
        n_compared++;
        if ({rsp_data, spi_input_data, spi_control} !== 71'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_data: got %h expected 0", {rsp_data, spi_input_data, spi_control});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_req(1, 32'hA5A5A5A5, 7'b0001000);
        req_valid = 4'b0010;
        tick();
        n_compared++;
        if (req_ready !== 4'b0010 || spi_start !== 1'b1 || busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL single_grant: got rdy=%b start=%b busy=%b expected 0010 1 1", req_ready, spi_start, busy);
        end
        n_compared++;
        if (spi_input_data !== 32'hA5A5A5A5 || spi_control !== 7'b0001000) begin
            n_mismatched++;
            $display("[TB] FAIL single_payload: got %h/%b expected a5a5a5a5/0001000", spi_input_data, spi_control);
        end
        req_valid = 4'b0000;
        tick();
        n_compared++;
        if (req_ready !== 4'b0000 || spi_start !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL single_hold: got rdy=%b start=%b expected 0000 1", req_ready, spi_start);
        end
        spi_done = 4'b0001;
        spi_output_data = 32'h5A5A5A5A;
        tick();
        spi_done = 4'b0000;
        n_compared++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 32'h5A5A5A5A || spi_start !== 1'b0 || rsp_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL single_rsp: got v=%b d=%h s=%b e=%b expected 0010 5a5a5a5a 0 0", rsp_valid, rsp_data, spi_start, rsp_err);
        end
        tick();
        n_compared++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_data !== 32'h5A5A5A5A) begin
            n_mismatched++;
            $display("[TB] FAIL single_idle: got v=%b busy=%b d=%h expected 0000 0 5a5a5a5a", rsp_valid, busy, rsp_data);
        end
    endtask

    task automatic test_all_four();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 32'h1000 + i, 7'(i + 1));
        req_valid = 4'b1111;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if (req_ready !== 4'(1 << i) || spi_input_data !== 32'h1000 + i) begin
                n_mismatched++;
                $display("[TB] FAIL order_%0d: got rdy=%b data=%h expected %b %h", i, req_ready, spi_input_data, 4'(1 << i), 32'h1000 + i);
            end
            req_valid[i] = 1'b0;
            spi_done = 4'b0001;
            spi_output_data = 32'hBEEF0000 + i;
            tick();
            spi_done = 4'b0000;
            n_compared++;
            if (rsp_valid !== 4'(1 << i) || rsp_data !== 32'hBEEF0000 + i || spi_start !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL order_rsp_%0d: got v=%b d=%h s=%b expected %b %h 0", i, rsp_valid, rsp_data, spi_start, 4'(1 << i), 32'hBEEF0000 + i);
            end
            tick();
            n_compared++;
            if (req_ready !== 4'b0000 || busy !== 1'b0 || spi_start !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL order_gap_%0d: got rdy=%b busy=%b s=%b expected 0000 0 0", i, req_ready, busy, spi_start);
            end
            tick();
        end
        n_compared++;
        if (req_ready !== 4'b0000 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL order_end: got rdy=%b busy=%b expected 0000 0", req_ready, busy);
        end
    endtask

    task automatic test_fairness();
        req_valid = 4'b0100;
        tick();
        n_compared++;
        if (req_ready !== 4'b0100) begin
            n_mismatched++;
            $display("[TB] FAIL rr_first: got %b expected 0100", req_ready);
        end
        req_valid = 4'b0000;
        complete_txn(32'h22);
        req_valid = 4'b1010;
        tick();
        n_compared++;
        if (req_ready !== 4'b1000) begin
            n_mismatched++;
            $display("[TB] FAIL rr_after2: got %b expected 1000", req_ready);
        end
        req_valid = 4'b0010;
        complete_txn(32'h33);
        tick();
        n_compared++;
        if (req_ready !== 4'b0010) begin
            n_mismatched++;
            $display("[TB] FAIL rr_wrap: got %b expected 0010", req_ready);
        end
        req_valid = 4'b0000;
        complete_txn(32'h11);
    endtask

    task automatic test_held_done();
        int pulses;
        int grants;
        pulses = 0;
        grants = 0;
        req_valid = 4'b0001;
        tick();
        n_compared++;
        if (req_ready !== 4'b0001) begin
            n_mismatched++;
            $display("[TB] FAIL held_grant: got %b expected 0001", req_ready);
        end
        req_valid = 4'b0100;
        spi_done = 4'b0001;
        spi_output_data = 32'hCAFE0001;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rsp_valid != 4'b0000) pulses++;
            if (req_ready != 4'b0000) grants++;
        end
        n_compared++;
        if (pulses !== 1 || grants !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL held_pulses: got rsp=%0d grants=%0d expected 1 0", pulses, grants);
        end
        spi_done = 4'b0000;
        tick();
        n_compared++;
        if (req_ready !== 4'b0000 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL held_exit: got rdy=%b busy=%b expected 0000 0", req_ready, busy);
        end
        tick();
        n_compared++;
        if (req_ready !== 4'b0100) begin
            n_mismatched++;
            $display("[TB] FAIL held_next: got %b expected 0100", req_ready);
        end
        req_valid = 4'b0000;
        complete_txn(32'h44);
    endtask

    task automatic test_reset_mid_busy();
        int pulses;
        pulses = 0;
        req_valid = 4'b0010;
        tick();
        n_compared++;
        if (req_ready !== 4'b0010) begin
            n_mismatched++;
            $display("[TB] FAIL mid_grant: got %b expected 0010", req_ready);
        end
        req_valid = 4'b0000;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        n_compared++;
        if ({req_ready, rsp_valid, busy, spi_start, rsp_err} !== 11'd0 || {rsp_data, spi_input_data, spi_control} !== 71'd0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_reset: got ctl=%b data=%h expected 0 0", {req_ready, rsp_valid, busy, spi_start, rsp_err}, {rsp_data, spi_input_data, spi_control});
        end
        spi_done = 4'b0001;
        repeat (2) begin
            tick();
            if (rsp_valid != 4'b0000) pulses++;
        end
        spi_done = 4'b0000;
        reset = 1'b1;
        req_valid = 4'b1111;
        tick();
        n_compared++;
        if (pulses !== 0 || req_ready !== 4'b0001) begin
            n_mismatched++;
            $display("[TB] FAIL mid_restart: got rsp=%0d rdy=%b expected 0 0001", pulses, req_ready);
        end
        req_valid = 4'b0000;
        complete_txn(32'h55);
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int early;
        early = 0;
        set_req(2, 32'h12345678, 7'h2A);
        req_valid = 4'b0100;
        spi_output_data = 32'hFFFFFFFF;
        tick();
        req_valid = 4'b0000;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (rsp_valid != 4'b0000) early++;
        end
        n_compared++;
        if (early !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_early: got %0d pulses expected 0", early);
        end
        tick();
        n_compared++;
        if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_data !== 32'd0 || spi_start !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_rsp: got v=%b e=%b d=%h s=%b expected 0100 1 0 0", rsp_valid, rsp_err, rsp_data, spi_start);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_held_done();
        test_reset_mid_busy();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
